exception_unit: RTL and testbench

Precise-exception arbiter between the MEM stage and the coprocessor-0 register file (`cp0`). Samples exception flags of the instruction in MEM, synchronises the six hardware interrupt lines, picks the single highest-priority cause, and issues one registered commit: cause code, EPC, branch-delay bit, and bad virtual address to `cp0`; flush and redirect PC to the pipeline. Also handles ERET redirection.

---
 rtl/exc_pkg.sv | 70 +++++++
 rtl/exception_unit_int_sync.sv | 25 ++
 rtl/exception_unit.sv | 152 +++++++++++++++
 tb/tb_exception_unit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared constants for the precise-exception arbiter: flag bit map, ExcCodes,
// vector bases/offsets, FSM state and the registered commit bundle.
package exc_pkg;

    localparam int HW_INT_W   = 6;
    localparam int EXC_FLAG_W = 15;

    // Flag bit indices, listed in priority order (ERET last)
    localparam int FLAG_F_ADEL       = 0;
    localparam int FLAG_F_TLB_REFILL = 1;
    localparam int FLAG_F_TLB_INV    = 2;
    localparam int FLAG_RI           = 3;
    localparam int FLAG_SYS          = 4;
    localparam int FLAG_BP           = 5;
    localparam int FLAG_OV           = 6;
    localparam int FLAG_L_ADEL       = 7;
    localparam int FLAG_S_ADES       = 8;
    localparam int FLAG_L_TLB_REFILL = 9;
    localparam int FLAG_L_TLB_INV    = 10;
    localparam int FLAG_S_TLB_REFILL = 11;
    localparam int FLAG_S_TLB_INV    = 12;
    localparam int FLAG_TLB_MOD      = 13;
    localparam int FLAG_ERET         = 14;

    localparam logic [EXC_FLAG_W-1:0] TLB_FLAG_MASK = 15'b011111000000110;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int ST_ERL = 2;
    localparam int ST_BEV = 22;

    localparam logic [31:0] VEC_BASE_BEV    = 32'hBFC0_0200;
    localparam logic [31:0] VEC_BASE_NORMAL = 32'h8000_0000;
    localparam logic [31:0] VEC_OFS_REFILL  = 32'h0000_0000;
    localparam logic [31:0] VEC_OFS_GENERAL = 32'h0000_0180;

    typedef enum logic {
        ST_IDLE,
        ST_COMMIT
    } state_e;

    typedef struct packed {
        logic        exc_valid;
        logic [4:0]  exc_code;
        logic [31:0] exc_epc;
        logic        exc_bd;
        logic [31:0] exc_badvaddr;
        logic        exc_badvaddr_we;
        logic        eret_valid;
        logic        flush;
        logic [31:0] new_pc;
    } commit_t;

    function automatic logic [31:0] vector_pc(input logic bev, input logic refill);
        return (bev ? VEC_BASE_BEV : VEC_BASE_NORMAL) +
               (refill ? VEC_OFS_REFILL : VEC_OFS_GENERAL);
    endfunction

endpackage

// File: rtl/exception_unit_int_sync.sv
// Two-flop synchroniser for the asynchronous hardware interrupt lines.
module exc_int_sync
    import exc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [HW_INT_W-1:0] d,
    output logic [HW_INT_W-1:0] q
);

    logic [HW_INT_W-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample the pre-edge values and the chain really is two flops deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Precise-exception arbiter: picks the highest-priority cause of the MEM
// instruction and issues a one-cycle registered commit. TLB causes and the
// refill vector are decoded only when EXC_TLB_EN is defined.
module exception_unit
    import exc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [HW_INT_W-1:0]   hw_int,
    input  logic                  mem_valid,
    input  logic [31:0]           mem_pc,
    input  logic                  mem_in_delayslot,
    input  logic [EXC_FLAG_W-1:0] mem_exc_flags,
    input  logic [31:0]           mem_bad_addr,
    input  logic [31:0]           cp0_status,
    input  logic [1:0]            cp0_cause_ip_sw,
    input  logic [31:0]           cp0_epc,
    output logic [HW_INT_W-1:0]   int_pending,
    output logic                  exc_valid,
    output logic [4:0]            exc_code,
    output logic [31:0]           exc_epc,
    output logic                  exc_bd,
    output logic [31:0]           exc_badvaddr,
    output logic                  exc_badvaddr_we,
    output logic                  eret_valid,
    output logic                  flush,
    output logic [31:0]           new_pc
);

    state_e                  state_q, state_d;
    commit_t                 commit_q, commit_d;
    logic [EXC_FLAG_W-1:0]   flags;
    logic                    int_req;
    logic                    cause_hit, cause_fetch, cause_bad, cause_refill;
    logic [4:0]              cause_code;
    logic                    unused_status;

    exc_int_sync u_int_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (hw_int),
        .q     (int_pending)
    );

`ifdef EXC_TLB_EN
    assign flags = mem_exc_flags;
`else
    assign flags = mem_exc_flags & ~TLB_FLAG_MASK;
`endif

    assign int_req = cp0_status[ST_IE] && !cp0_status[ST_EXL] && !cp0_status[ST_ERL] &&
                     (({int_pending, cp0_cause_ip_sw} & cp0_status[15:8]) != 8'd0);

    assign unused_status = ^{cp0_status[31:23], cp0_status[21:16], cp0_status[7:3]};

    // NOTE: every combinational output gets a default first so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        cause_hit    = 1'b1;
        cause_code   = EXC_INT;
        cause_fetch  = 1'b0;
        cause_bad    = 1'b0;
        cause_refill = 1'b0;
        if (int_req) begin
            cause_code = EXC_INT;
        end else if (flags[FLAG_F_ADEL]) begin
            cause_code = EXC_ADEL; cause_fetch = 1'b1; cause_bad = 1'b1;
        end else if (flags[FLAG_F_TLB_REFILL]) begin
            cause_code = EXC_TLBL; cause_fetch = 1'b1; cause_bad = 1'b1; cause_refill = 1'b1;
        end else if (flags[FLAG_F_TLB_INV]) begin
            cause_code = EXC_TLBL; cause_fetch = 1'b1; cause_bad = 1'b1;
        end else if (flags[FLAG_RI]) begin
            cause_code = EXC_RI;
        end else if (flags[FLAG_SYS]) begin
            cause_code = EXC_SYS;
        end else if (flags[FLAG_BP]) begin
            cause_code = EXC_BP;
        end else if (flags[FLAG_OV]) begin
            cause_code = EXC_OV;
        end else if (flags[FLAG_L_ADEL]) begin
            cause_code = EXC_ADEL; cause_bad = 1'b1;
        end else if (flags[FLAG_S_ADES]) begin
            cause_code = EXC_ADES; cause_bad = 1'b1;
        end else if (flags[FLAG_L_TLB_REFILL]) begin
            cause_code = EXC_TLBL; cause_bad = 1'b1; cause_refill = 1'b1;
        end else if (flags[FLAG_L_TLB_INV]) begin
            cause_code = EXC_TLBL; cause_bad = 1'b1;
        end else if (flags[FLAG_S_TLB_REFILL]) begin
            cause_code = EXC_TLBS; cause_bad = 1'b1; cause_refill = 1'b1;
        end else if (flags[FLAG_S_TLB_INV]) begin
            cause_code = EXC_TLBS; cause_bad = 1'b1;
        end else if (flags[FLAG_TLB_MOD]) begin
            cause_code = EXC_MOD; cause_bad = 1'b1;
        end else begin
            cause_hit = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        commit_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid && cause_hit) begin
                    commit_d.exc_valid       = 1'b1;
                    commit_d.exc_code        = cause_code;
                    commit_d.exc_epc         = mem_in_delayslot ? mem_pc - 32'd4 : mem_pc;
                    commit_d.exc_bd          = mem_in_delayslot;
                    commit_d.exc_badvaddr_we = cause_bad;
                    commit_d.exc_badvaddr    = !cause_bad ? 32'd0 :
                                               (cause_fetch ? mem_pc : mem_bad_addr);
                    commit_d.flush           = 1'b1;
                    // Refill vector only when not already at exception level
                    commit_d.new_pc          = vector_pc(cp0_status[ST_BEV],
                                                         cause_refill && !cp0_status[ST_EXL]);
                    state_d                  = ST_COMMIT;
                end else if (mem_valid && flags[FLAG_ERET]) begin
                    commit_d.eret_valid = 1'b1;
                    commit_d.flush      = 1'b1;
                    commit_d.new_pc     = cp0_epc;
                    state_d             = ST_COMMIT;
                end
            end
            // The MEM instruction is being flushed, so its inputs are ignored
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: the output register is part of the reset domain so a reset landing
    // mid-commit drops every strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            commit_q <= '0;
        end else begin
            state_q  <= state_d;
            commit_q <= commit_d;
        end
    end

    assign exc_valid       = commit_q.exc_valid;
    assign exc_code        = commit_q.exc_code;
    assign exc_epc         = commit_q.exc_epc;
    assign exc_bd          = commit_q.exc_bd;
    assign exc_badvaddr    = commit_q.exc_badvaddr;
    assign exc_badvaddr_we = commit_q.exc_badvaddr_we;
    assign eret_valid      = commit_q.eret_valid;
    assign flush           = commit_q.flush;
    assign new_pc          = commit_q.new_pc;

endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit: a priority-table reference model pushes
// expected commits; an independent monitor pops and compares them.
module tb_exception_unit;
    import exc_pkg::*;

`ifdef EXC_TLB_EN
    localparam bit TLB_EN = 1'b1;
`else
    localparam bit TLB_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [5:0]            hw_int;
    logic                  mem_valid;
    logic [31:0]           mem_pc;
    logic                  mem_in_delayslot;
    logic [EXC_FLAG_W-1:0] mem_exc_flags;
    logic [31:0]           mem_bad_addr;
    logic [31:0]           cp0_status;
    logic [1:0]            cp0_cause_ip_sw;
    logic [31:0]           cp0_epc;
    logic [5:0]            int_pending;
    logic                  exc_valid;
    logic [4:0]            exc_code;
    logic [31:0]           exc_epc;
    logic                  exc_bd;
    logic [31:0]           exc_badvaddr;
    logic                  exc_badvaddr_we;
    logic                  eret_valid;
    logic                  flush;
    logic [31:0]           new_pc;

    exception_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hw_int           (hw_int),
        .mem_valid        (mem_valid),
        .mem_pc           (mem_pc),
        .mem_in_delayslot (mem_in_delayslot),
        .mem_exc_flags    (mem_exc_flags),
        .mem_bad_addr     (mem_bad_addr),
        .cp0_status       (cp0_status),
        .cp0_cause_ip_sw  (cp0_cause_ip_sw),
        .cp0_epc          (cp0_epc),
        .int_pending      (int_pending),
        .exc_valid        (exc_valid),
        .exc_code         (exc_code),
        .exc_epc          (exc_epc),
        .exc_bd           (exc_bd),
        .exc_badvaddr     (exc_badvaddr),
        .exc_badvaddr_we  (exc_badvaddr_we),
        .eret_valid       (eret_valid),
        .flush            (flush),
        .new_pc           (new_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stamp;
        logic        exc_valid;
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic [31:0] badv;
        logic        badv_we;
        logic        eret;
        logic [31:0] new_pc;
    } exp_t;

    typedef struct {
        int idx;
        int code;
        bit fetch;
        bit bad;
        bit refill;
        bit tlb;
    } prio_t;

    exp_t       sb[$];
    prio_t      prio[14];
    logic [5:0] hist[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         since_rst = 0;
    bit         busy = 1'b0;
    logic [5:0] hw_cur = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_status(input bit ie, input bit exl, input bit erl,
                                              input logic [7:0] im, input bit bev);
        logic [31:0] s;
        s = '0;
        s[0] = ie; s[1] = exl; s[2] = erl; s[15:8] = im; s[22] = bev;
        return s;
    endfunction

    // Reference: interrupt first, then the first flag in table order, then ERET
    function automatic bit model(input logic v, input logic [31:0] pc, input logic ds,
                                 input logic [EXC_FLAG_W-1:0] fl, input logic [31:0] bad,
                                 input logic [31:0] st, input logic [1:0] sw,
                                 input logic [31:0] epc, input logic [5:0] pend,
                                 output exp_t e);
        logic [31:0] base;
        e = '{default: 0};
        if (!v) return 1'b0;
        base = st[22] ? 32'hBFC0_0200 : 32'h8000_0000;
        e.exc_valid = 1'b1;
        e.epc = ds ? pc - 32'd4 : pc;
        e.bd = ds;
        if (st[0] && !st[1] && !st[2] && (({pend, sw} & st[15:8]) != 8'd0)) begin
            e.code = 5'd0;
            e.new_pc = base + 32'h180;
            return 1'b1;
        end
        foreach (prio[i]) begin
            if (fl[prio[i].idx] && (TLB_EN || !prio[i].tlb)) begin
                e.code = 5'(prio[i].code);
                e.badv_we = prio[i].bad;
                e.badv = !prio[i].bad ? 32'd0 : (prio[i].fetch ? pc : bad);
                e.new_pc = base + ((prio[i].refill && !st[1]) ? 32'h0 : 32'h180);
                return 1'b1;
            end
        end
        if (fl[FLAG_ERET]) begin
            e = '{default: 0};
            e.eret = 1'b1;
            e.new_pc = epc;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic step(input logic v, input logic [31:0] pc, input logic ds,
                        input logic [EXC_FLAG_W-1:0] fl, input logic [31:0] bad,
                        input logic [31:0] st, input logic [1:0] sw, input logic [31:0] epc,
                        input logic [5:0] hw);
        exp_t       e;
        logic [5:0] pend;
        @(negedge clk);
        cyc++;
        mem_valid = v; mem_pc = pc; mem_in_delayslot = ds; mem_exc_flags = fl;
        mem_bad_addr = bad; cp0_status = st; cp0_cause_ip_sw = sw; cp0_epc = epc; hw_int = hw;
        pend = (since_rst >= 2) ? hist[since_rst-2] : 6'd0;
        check("int_pending", 32'(int_pending), 32'(pend));
        hist.push_back(hw);
        since_rst++;
        if (!busy && model(v, pc, ds, fl, bad, st, sw, epc, pend, e)) begin
            e.stamp = cyc;
            sb.push_back(e);
            busy = 1'b1;
        end else begin
            busy = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, '0, 32'd0, 32'd0, 2'd0, 32'd0, hw_cur);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, {28'd0, exc_valid, eret_valid, flush, exc_badvaddr_we}, 32'd0);
        check({tag, "_new_pc"}, new_pc, 32'd0);
        check({tag, "_epc"}, exc_epc, 32'd0);
        check({tag, "_code_bd"}, {26'd0, exc_code, exc_bd}, 32'd0);
        check({tag, "_badvaddr"}, exc_badvaddr, 32'd0);
        check({tag, "_int_pending"}, 32'(int_pending), 32'd0);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard head
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exc_valid || eret_valid || flush) begin
                if (sb.size() == 0) begin
                    check("spurious_commit", {29'd0, exc_valid, eret_valid, flush}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("commit_cycle", cyc, e.stamp);
                    check("exc_valid", 32'(exc_valid), 32'(e.exc_valid));
                    check("exc_code", 32'(exc_code), 32'(e.code));
                    check("exc_epc", exc_epc, e.epc);
                    check("exc_bd", 32'(exc_bd), 32'(e.bd));
                    check("exc_badvaddr", exc_badvaddr, e.badv);
                    check("exc_badvaddr_we", 32'(exc_badvaddr_we), 32'(e.badv_we));
                    check("eret_valid", 32'(eret_valid), 32'(e.eret));
                    check("flush", 32'(flush), 32'd1);
                    check("new_pc", new_pc, e.new_pc);
                end
            end else if (sb.size() != 0 && sb[0].stamp <= cyc) begin
                check("missing_commit_flush", 32'(flush), 32'd1);
                void'(sb.pop_front());
            end else begin
                check("idle_new_pc", new_pc, 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] st_int;
        logic [EXC_FLAG_W-1:0] fl;
        prio[0]  = '{FLAG_F_ADEL,       4,  1, 1, 0, 0};
        prio[1]  = '{FLAG_F_TLB_REFILL, 2,  1, 1, 1, 1};
        prio[2]  = '{FLAG_F_TLB_INV,    2,  1, 1, 0, 1};
        prio[3]  = '{FLAG_RI,           10, 0, 0, 0, 0};
        prio[4]  = '{FLAG_SYS,          8,  0, 0, 0, 0};
        prio[5]  = '{FLAG_BP,           9,  0, 0, 0, 0};
        prio[6]  = '{FLAG_OV,           12, 0, 0, 0, 0};
        prio[7]  = '{FLAG_L_ADEL,       4,  0, 1, 0, 0};
        prio[8]  = '{FLAG_S_ADES,       5,  0, 1, 0, 0};
        prio[9]  = '{FLAG_L_TLB_REFILL, 2,  0, 1, 1, 1};
        prio[10] = '{FLAG_L_TLB_INV,    2,  0, 1, 0, 1};
        prio[11] = '{FLAG_S_TLB_REFILL, 3,  0, 1, 1, 1};
        prio[12] = '{FLAG_S_TLB_INV,    3,  0, 1, 0, 1};
        prio[13] = '{FLAG_TLB_MOD,      1,  0, 1, 0, 1};

        rst_n = 1'b0; hw_int = '0; mem_valid = 1'b0; mem_pc = '0; mem_in_delayslot = 1'b0;
        mem_exc_flags = '0; mem_bad_addr = '0; cp0_status = '0; cp0_cause_ip_sw = '0; cp0_epc = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Syscall, then Ov in a delay slot, then delay slot at pc 0
        step(1, 32'h8000_1000, 0, 15'(1) << FLAG_SYS, 0, mk_status(0, 0, 0, 8'h00, 0), 0, 0, 0);
        idle(1);
        step(1, 32'h8000_2004, 1, 15'(1) << FLAG_OV, 0, mk_status(0, 0, 0, 8'h00, 0), 0, 0, 0);
        idle(1);
        step(1, 32'h0000_0000, 1, 15'(1) << FLAG_BP, 0, mk_status(0, 0, 0, 8'h00, 1), 0, 0, 0);
        // Back-to-back flagged instructions: second one lands in COMMIT
        step(1, 32'h8000_2100, 0, 15'(1) << FLAG_RI, 0, mk_status(0, 0, 0, 8'h00, 0), 0, 0, 0);
        idle(1);

        // Hardware interrupt 0 with IM[2], then blocked by EXL
        hw_cur = 6'b000001;
        st_int = mk_status(1, 0, 0, 8'b0000_0100, 0);
        idle(2);
        step(1, 32'h8000_4000, 0, 15'(1) << FLAG_OV, 0, st_int, 0, 0, hw_cur);
        idle(1);
        step(1, 32'h8000_4004, 0, '0, 0, mk_status(1, 1, 0, 8'b0000_0100, 0), 0, 0, hw_cur);
        hw_cur = '0;
        idle(3);

        // Store AdES together with RI: RI wins
        step(1, 32'h8000_5000, 0, (15'(1) << FLAG_S_ADES) | (15'(1) << FLAG_RI), 32'h3,
             mk_status(0, 0, 0, 8'h00, 0), 0, 0, 0);
        idle(1);
        step(1, 32'h8000_5010, 0, 15'(1) << FLAG_S_ADES, 32'h3, mk_status(0, 0, 0, 8'h00, 0), 0, 0, 0);
        idle(1);
        // Fetch TLB refill with BEV=1 (ignored when TLB decoding is disabled)
        step(1, 32'h8000_6000, 0, 15'(1) << FLAG_F_TLB_REFILL, 32'h1234,
             mk_status(0, 0, 0, 8'h00, 1), 0, 0, 0);
        idle(1);
        step(1, 32'h8000_6100, 0, 15'(1) << FLAG_S_TLB_REFILL, 32'h7777_0000,
             mk_status(0, 1, 0, 8'h00, 0), 0, 0, 0);
        idle(1);

        // ERET, then reset in the middle of its COMMIT cycle
        step(1, 32'h8000_7000, 0, 15'(1) << FLAG_ERET, 0, mk_status(0, 1, 0, 8'h00, 0), 0,
             32'h8000_3000, 0);
        @(negedge clk);
        rst_n = 1'b0;
        mem_valid = 1'b0; mem_exc_flags = '0; hw_int = '0;
        #1;
        check_all_zero("reset_in_commit");
        busy = 1'b0; since_rst = 0; hist.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       fl = '0;
                1:       fl = 15'(1) << $urandom_range(0, 14);
                2:       fl = (15'(1) << $urandom_range(0, 14)) | (15'(1) << $urandom_range(0, 14));
                default: fl = 15'($urandom) & 15'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) hw_cur = 6'($urandom) & 6'($urandom);
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFC),
                 1'($urandom), fl, $urandom,
                 mk_status($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 7) == 0, 8'($urandom), 1'($urandom)),
                 2'($urandom) & 2'($urandom), $urandom, hw_cur);
        end
        idle(3);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
